// File: rtl/rtl_bigreg_writer_pkg.sv
// Shared mem-map layout constants, FSM state type and the request legality helper
// used by the RTL_BIGREG writer.
package mem_layout_pkg;

   localparam int MEM_SIZE  = 256;
   localparam int DATA_W    = 16;
   localparam int NUM_REQ   = 2;
   localparam int MAX_WORDS = 2;
   localparam int ID_W      = $clog2(MEM_SIZE);
   localparam int CNT_W     = $clog2(MAX_WORDS + 1);
   localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [DATA_W-1:0] RTL_VALID_WORD = 16'h0001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      VALID = 2'd2
   } wr_state_e;

   // Index MEM_SIZE-1 is the -2 sentinel and must never be the last word written.
   function automatic logic req_is_legal(input logic [ID_W-1:0]  base,
                                         input logic [CNT_W-1:0] num,
                                         input logic             valid_en);
      logic [ID_W+1:0] last_id;
      last_id = {2'b00, base} + (ID_W+2)'(num) + (ID_W+2)'(valid_en) - (ID_W+2)'(1);
      return (num != '0) && (last_id < (ID_W+2)'(MEM_SIZE - 1));
   endfunction

endpackage

// File: rtl/rtl_bigreg_writer_if.sv
// RTL-side mem-map write port: one 16-bit word per valid/ready beat.
interface rtl_bigreg_writer_if;

   logic                              wr_valid;
   logic                              wr_ready;
   logic [mem_layout_pkg::ID_W-1:0]   wr_id;
   logic [mem_layout_pkg::DATA_W-1:0] wr_data;

   modport master (
      output wr_valid,
      output wr_id,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_id,
      input  wr_data,
      output wr_ready
   );

endinterface

// File: rtl/rtl_bigreg_writer_rr_arbiter.sv
// Combinational round-robin priority rotation; the search starts just after 'last'.
// The pointer register lives in the parent.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic             advance,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 1; off <= N; off++) begin
         idx = (int'(last) + off) % N;
         if (advance && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rtl_bigreg_writer.sv
// Serialises multi-word RTL_BIGREG updates from several producers onto the mem-map write port.
//   state | meaning
//   IDLE  | arbitrate producers, latch and check the winning request
//   WRITE | emit data word k at base+k, lowest word first
//   VALID | emit RTL_VALID_WORD at base+num_words
module rtl_bigreg_writer
   import mem_layout_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    req_valid_i,
   output logic [NUM_REQ-1:0]                    req_ready_o,
   input  logic [NUM_REQ*MAX_WORDS*DATA_W-1:0]   req_data_i,
   input  logic [NUM_REQ*ID_W-1:0]               req_base_id_i,
   input  logic [NUM_REQ*CNT_W-1:0]              req_num_words_i,
   input  logic [NUM_REQ-1:0]                    req_valid_en_i,
   rtl_bigreg_writer_if.master                   wr,
   output logic                                  busy_o,
   output logic                                  err_o
);

   wr_state_e                     state_q, state_d;
   logic [REQ_IDX_W-1:0]          ptr_q, ptr_d;
   logic [MAX_WORDS*DATA_W-1:0]   data_q, data_d;
   logic [ID_W-1:0]               base_q, base_d;
   logic [CNT_W-1:0]              num_q, num_d;
   logic                          ven_q, ven_d;
   logic [CNT_W-1:0]              k_q, k_d;

   logic [NUM_REQ-1:0]            arb_grant;
   logic [REQ_IDX_W-1:0]          arb_idx;
   logic                          arb_any;
   logic                          arb_advance;

   logic [MAX_WORDS*DATA_W-1:0]   sel_data;
   logic [ID_W-1:0]               sel_base;
   logic [CNT_W-1:0]              sel_num;
   logic                          sel_ven;
   logic                          sel_legal;
   logic                          accept;
   logic                          hs;
   logic                          last_word;

   // No grant while reset is asserted, so req_ready stays low during reset.
   assign arb_advance = (state_q == IDLE) && !rst;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (REQ_IDX_W)
   ) u_rr_arbiter (
      .req       (req_valid_i),
      .advance   (arb_advance),
      .last      (ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   assign arb_any   = |arb_grant;
   assign sel_data  = req_data_i[int'(arb_idx)*MAX_WORDS*DATA_W +: MAX_WORDS*DATA_W];
   assign sel_base  = req_base_id_i[int'(arb_idx)*ID_W +: ID_W];
   assign sel_num   = req_num_words_i[int'(arb_idx)*CNT_W +: CNT_W];
   assign sel_ven   = req_valid_en_i[arb_idx];
   assign sel_legal = req_is_legal(sel_base, sel_num, sel_ven);
   assign accept    = arb_any && sel_legal;
   assign hs        = wr.wr_valid && wr.wr_ready;
   assign last_word = (k_q == (num_q - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= REQ_IDX_W'(NUM_REQ - 1);
         data_q  <= '0;
         base_q  <= '0;
         num_q   <= '0;
         ven_q   <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         base_q  <= base_d;
         num_q   <= num_d;
         ven_q   <= ven_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = WRITE;
         end
         WRITE: begin
            if (hs && last_word) state_d = ven_q ? VALID : IDLE;
         end
         VALID: begin
            if (hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Rejected grants still move the pointer so a bad producer cannot starve the others.
   always_comb begin
      ptr_d  = ptr_q;
      data_d = data_q;
      base_d = base_q;
      num_d  = num_q;
      ven_d  = ven_q;
      k_d    = k_q;
      if (arb_any) ptr_d = arb_idx;
      if (accept) begin
         data_d = sel_data;
         base_d = sel_base;
         num_d  = sel_num;
         ven_d  = sel_ven;
         k_d    = '0;
      end
      if ((state_q == WRITE) && hs && !last_word) k_d = k_q + CNT_W'(1);
   end

   always_comb begin
      req_ready_o = arb_grant;
      err_o       = arb_any && !sel_legal;
      busy_o      = (state_q != IDLE);
      wr.wr_valid = 1'b0;
      wr.wr_id    = '0;
      wr.wr_data  = '0;
      case (state_q)
         WRITE: begin
            wr.wr_valid = 1'b1;
            wr.wr_id    = base_q + ID_W'(k_q);
            wr.wr_data  = data_q[int'(k_q)*DATA_W +: DATA_W];
         end
         VALID: begin
            wr.wr_valid = 1'b1;
            wr.wr_id    = base_q + ID_W'(num_q);
            wr.wr_data  = RTL_VALID_WORD;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rtl_bigreg_writer.sv
// Directed bench for rtl_bigreg_writer: timestamp and PWL writes, fairness, backpressure,
// range rejection and mid-transfer reset.
module tb_rtl_bigreg_writer;
   import mem_layout_pkg::*;

   logic                                clk = 1'b0;
   logic                                rst;
   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0]                  req_ready;
   logic [NUM_REQ*MAX_WORDS*DATA_W-1:0] req_data;
   logic [NUM_REQ*ID_W-1:0]             req_base_id;
   logic [NUM_REQ*CNT_W-1:0]            req_num_words;
   logic [NUM_REQ-1:0]                  req_valid_en;
   logic                                busy;
   logic                                err;

   int n_checks = 0;
   int n_fail   = 0;

   rtl_bigreg_writer_if wr_bus ();

   always #5 clk = ~clk;

   rtl_bigreg_writer dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_data_i      (req_data),
      .req_base_id_i   (req_base_id),
      .req_num_words_i (req_num_words),
      .req_valid_en_i  (req_valid_en),
      .wr              (wr_bus),
      .busy_o          (busy),
      .err_o           (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int p, input logic [ID_W-1:0] base, input logic [CNT_W-1:0] num,
                          input logic [31:0] data, input logic ven);
      req_base_id[p*ID_W +: ID_W]              = base;
      req_num_words[p*CNT_W +: CNT_W]          = num;
      req_data[p*MAX_WORDS*DATA_W +: 32]       = data;
      req_valid_en[p]                          = ven;
   endtask

   // Checks every output at the falling edge, then moves to just after the next rising edge.
   task automatic cyc(input string tag, input logic [1:0] rdy, input logic er, input logic v,
                      input logic [7:0] id, input logic [15:0] d, input logic bz);
      @(negedge clk);
      check({tag, ".ready"}, 64'(req_ready), 64'(rdy));
      check({tag, ".err"},   64'(err),       64'(er));
      check({tag, ".valid"}, 64'(wr_bus.wr_valid), 64'(v));
      check({tag, ".id"},    64'(wr_bus.wr_id),    64'(id));
      check({tag, ".data"},  64'(wr_bus.wr_data),  64'(d));
      check({tag, ".busy"},  64'(busy),            64'(bz));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      req_valid        = '0;
      wr_bus.wr_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      req_data      = '0;
      req_base_id   = '0;
      req_num_words = '0;
      req_valid_en  = '0;
      do_reset();
      cyc("reset", 2'b00, 0, 0, 8'd0, 16'h0000, 0);

      // Single timestamp write with valid word
      set_req(0, 8'd29, 2'd2, 32'hDEAD_BEEF, 1'b1);
      req_valid = 2'b01;
      cyc("ts.grant", 2'b01, 0, 0, 8'd0, 16'h0000, 0);
      req_valid = 2'b00;
      cyc("ts.w0",    2'b00, 0, 1, 8'd29, 16'hBEEF, 1);
      cyc("ts.w1",    2'b00, 0, 1, 8'd30, 16'hDEAD, 1);
      cyc("ts.vw",    2'b00, 0, 1, 8'd31, 16'h0001, 1);
      cyc("ts.idle",  2'b00, 0, 0, 8'd0,  16'h0000, 0);

      // Both producers after reset: p0 first, then p1, then p0 again
      do_reset();
      set_req(0, 8'd26, 2'd2, 32'h0001_2345, 1'b0);
      set_req(1, 8'd29, 2'd2, 32'hDEAD_BEEF, 1'b1);
      req_valid = 2'b11;
      cyc("both.g0",   2'b01, 0, 0, 8'd0,  16'h0000, 0);
      req_valid = 2'b10;
      cyc("both.p0w0", 2'b00, 0, 1, 8'd26, 16'h2345, 1);
      cyc("both.p0w1", 2'b00, 0, 1, 8'd27, 16'h0001, 1);
      req_valid = 2'b11;
      cyc("both.g1",   2'b10, 0, 0, 8'd0,  16'h0000, 0);
      req_valid = 2'b01;
      cyc("both.p1w0", 2'b00, 0, 1, 8'd29, 16'hBEEF, 1);
      cyc("both.p1w1", 2'b00, 0, 1, 8'd30, 16'hDEAD, 1);
      cyc("both.p1vw", 2'b00, 0, 1, 8'd31, 16'h0001, 1);
      req_valid = 2'b11;
      cyc("both.g2",   2'b01, 0, 0, 8'd0,  16'h0000, 0);
      req_valid = 2'b00;
      cyc("both.p0w0b", 2'b00, 0, 1, 8'd26, 16'h2345, 1);
      cyc("both.p0w1b", 2'b00, 0, 1, 8'd27, 16'h0001, 1);
      cyc("both.idle",  2'b00, 0, 0, 8'd0,  16'h0000, 0);

      // Backpressure on word 1
      set_req(0, 8'd29, 2'd2, 32'hDEAD_BEEF, 1'b1);
      req_valid = 2'b01;
      cyc("bp.grant", 2'b01, 0, 0, 8'd0,  16'h0000, 0);
      req_valid = 2'b00;
      cyc("bp.w0",    2'b00, 0, 1, 8'd29, 16'hBEEF, 1);
      wr_bus.wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("bp.hold", 2'b00, 0, 1, 8'd30, 16'hDEAD, 1);
      wr_bus.wr_ready = 1'b1;
      cyc("bp.w1",    2'b00, 0, 1, 8'd30, 16'hDEAD, 1);
      cyc("bp.vw",    2'b00, 0, 1, 8'd31, 16'h0001, 1);
      cyc("bp.idle",  2'b00, 0, 0, 8'd0,  16'h0000, 0);

      // Out-of-range and zero-length rejections, then the highest legal placement
      set_req(0, 8'd254, 2'd1, 32'h0000_1111, 1'b1);
      req_valid = 2'b01;
      cyc("oor.grant", 2'b01, 1, 0, 8'd0, 16'h0000, 0);
      req_valid = 2'b00;
      cyc("oor.after", 2'b00, 0, 0, 8'd0, 16'h0000, 0);
      set_req(0, 8'd10, 2'd0, 32'h0000_2222, 1'b0);
      req_valid = 2'b01;
      cyc("zero.grant", 2'b01, 1, 0, 8'd0, 16'h0000, 0);
      req_valid = 2'b00;
      cyc("zero.after", 2'b00, 0, 0, 8'd0, 16'h0000, 0);
      set_req(0, 8'd253, 2'd1, 32'h0000_00AA, 1'b1);
      req_valid = 2'b01;
      cyc("edge.grant", 2'b01, 0, 0, 8'd0,   16'h0000, 0);
      req_valid = 2'b00;
      cyc("edge.w0",    2'b00, 0, 1, 8'd253, 16'h00AA, 1);
      cyc("edge.vw",    2'b00, 0, 1, 8'd254, 16'h0001, 1);
      cyc("edge.idle",  2'b00, 0, 0, 8'd0,   16'h0000, 0);

      // Reset during the second beat abandons the transfer and resets the pointer
      set_req(0, 8'd29, 2'd2, 32'hDEAD_BEEF, 1'b1);
      req_valid = 2'b01;
      cyc("rm.grant", 2'b01, 0, 0, 8'd0,  16'h0000, 0);
      req_valid = 2'b00;
      cyc("rm.w0",    2'b00, 0, 1, 8'd29, 16'hBEEF, 1);
      rst = 1'b1;
      cyc("rm.w1",    2'b00, 0, 1, 8'd30, 16'hDEAD, 1);
      rst = 1'b0;
      cyc("rm.after", 2'b00, 0, 0, 8'd0,  16'h0000, 0);
      set_req(0, 8'd40, 2'd1, 32'h0000_7777, 1'b0);
      set_req(1, 8'd26, 2'd2, 32'h0001_2345, 1'b0);
      req_valid = 2'b11;
      cyc("rm.ptr",   2'b01, 0, 0, 8'd0,  16'h0000, 0);
      req_valid = 2'b10;
      cyc("rm.p0w0",  2'b00, 0, 1, 8'd40, 16'h7777, 1);
      cyc("rm.g1",    2'b10, 0, 0, 8'd0,  16'h0000, 0);
      req_valid = 2'b00;
      cyc("rm.p1w0",  2'b00, 0, 1, 8'd26, 16'h2345, 1);
      cyc("rm.p1w1",  2'b00, 0, 1, 8'd27, 16'h0001, 1);
      cyc("rm.idle",  2'b00, 0, 0, 8'd0,  16'h0000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rtl_bigreg_writer.md
Name: rtl_bigreg_writer

Overview:
- Serialises multi-word RTL_BIGREG updates from several RTL producers into the single RTL-side mem-map write port.
- Typical producers: the PWL period (ids 26/27) and the buffer timestamp (ids 29/30, with the valid word at id 31).
- Round-robin arbitration between producers; each value is written one 16-bit word per accepted beat, lowest word first, optionally followed by a valid-word write.
- Sits between the producers and the mem-map RTL write port.

Parameters:
- NUM_REQ, 2, number of producers.
- MAX_WORDS, 2, maximum 16-bit words per request.
- DATA_W, 16, mem-map word width (WD_DATA_WIDTH).
- MEM_SIZE, 256, mem-map depth.
- ID_W, $clog2(MEM_SIZE) = 8, mem-map index width.
- CNT_W, $clog2(MAX_WORDS+1), word-count width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-producer request
- req_ready  out  NUM_REQ  one-cycle acceptance pulse per producer
- req_data  in  NUM_REQ*MAX_WORDS*DATA_W  packed value; word k of producer i at [(i*MAX_WORDS+k)*DATA_W +: DATA_W]
- req_base_id  in  NUM_REQ*ID_W  first mem-map index
- req_num_words  in  NUM_REQ*CNT_W  words to write (0..MAX_WORDS)
- req_valid_en  in  NUM_REQ  1 = write 16'h0001 to base_id+num_words after the data words
- wr_valid  out  1  write beat valid
- wr_ready  in  1  mem map accepts the beat
- wr_id  out  ID_W  target index
- wr_data  out  DATA_W  target word
- busy  out  1  high outside IDLE
- err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Round-robin pointer set to NUM_REQ-1, so producer 0 has first priority. Reset mid-transfer abandons the transfer: no further beats, no valid write.
- States: IDLE, WRITE, VALID.
- IDLE arbitration:
  - Search starts at pointer+1 and wraps; first asserted req_valid wins.
  - In the same cycle: pulse req_ready[winner]; latch data, base, count and valid_en; pointer <= winner.
  - Arbitration is combinational on req_valid; the first wr_valid follows one cycle after grant.
- Legality check (at grant):
  - Reject if num_words==0, or if last_id = base + num_words - 1 + valid_en >= MEM_SIZE-1. Compute in ID_W+2 bits; index MEM_SIZE-1 (-2 sentinel) is never writable.
  - On reject: req_ready still pulses, err pulses the same cycle, pointer still advances, FSM stays in IDLE.
- WRITE:
  - wr_valid=1, wr_id=base+k, wr_data=word k, starting at k=0.
  - On wr_valid&wr_ready: if k==num_words-1, go to VALID when valid_en else IDLE; otherwise k++.
  - wr_id/wr_data hold stable while wr_ready is low (AXI-style: no withdrawal).
- VALID: wr_valid=1, wr_id=base+num_words, wr_data=16'h0001; on handshake go to IDLE.
- Throughput: back-to-back beats when wr_ready is held high. One idle cycle between requests (re-arbitration in IDLE). Minimum occupancy = num_words + valid_en + 1 cycles.
- Producer contract: a producer keeps req_valid and its fields stable until req_ready. Data is captured at grant, so the producer may change fields the cycle after req_ready.
- busy = (state != IDLE).
- A request arriving while busy waits; no loss, no queue beyond the producer's own hold.
- Simultaneous requests in IDLE: exactly one req_ready bit per cycle.

Decomposition:
- Package mem_layout_pkg gains:
  - RTL_VALID_WORD (16'h0001);
  - localparams ID_W=$clog2(`MEM_SIZE) and CNT_W;
  - a typedef enum {IDLE, WRITE, VALID} for the FSM.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], advance, last;
  - outputs one-hot grant and grant_idx;
  - pure combinational priority rotation. The pointer register stays in the parent.

Test Plan:
- Buffer-timestamp request: base 29, 2 words, data 32'hDEAD_BEEF, valid_en=1, wr_ready=1 -> beats (29,BEEF), (30,DEAD), (31,0001) on consecutive cycles; req_ready pulses one cycle before the first beat.
- Both producers request in the same cycle after reset:
  - p0 = PWL period (base 26, 2 words, 32'h0001_2345, valid_en=0);
  - p1 = timestamp as above;
  - Expected: p0 served first with (26,2345), (27,0001); then p1; then with both held, p0 wins again (fairness alternates).
- Backpressure: wr_ready low for 3 cycles during word 1 -> wr_id/wr_data held at (30,DEAD); no duplicate or skipped beat.
- Out of range: base 254, 1 word, valid_en=1 (last_id 255) -> req_ready and err pulse together, no wr_valid. Same for num_words=0.
- rst asserted during the second beat -> next cycle wr_valid=0, busy=0, pointer reset. A fresh p1-only request is then served normally.
